vgm_sva_expect_tracker: RTL and testbench
=========================================

Name: vgm_sva_expect_tracker

Overview:
- Hardware stage directly downstream of `expect` pass/fail action blocks in SVUnit assertion tests. Consumes one-cycle pass/fail event pulses.
- Keeps the sticky `pass_called`/`fail_called` flags and saturating event counters.
- Resolves armed expectation windows to pass/fail/timeout, so benches check a registered result instead of variables written from action blocks.

Parameters:
- CNT_W, 16, width of pass/fail event counters (saturating).
- TIMEOUT_W, 16, width of timeout_cycles and the internal window down-counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  opens (or restarts) an expectation window.
- timeout_cycles  in  TIMEOUT_W  window length, latched on arm; 0 = no timeout.
- pass_evt  in  1  pulse from expect pass block.
- fail_evt  in  1  pulse from expect fail block.
- clear  in  1  clears sticky flags, counters, double_evt.
- pass_called  out  1  sticky: a pass event seen since reset/clear.
- fail_called  out  1  sticky: a fail event seen since reset/clear.
- double_evt  out  1  sticky: pass+fail same cycle, or a second event in an armed window.
- busy  out  1  high while in ARMED.
- done  out  1  one-cycle pulse when a window resolves.
- status  out  2  window result: 00 none, 01 pass, 10 fail, 11 timeout.
- pass_count  out  CNT_W  total pass events, saturates at all-ones.
- fail_count  out  CNT_W  total fail events, saturates at all-ones.

Behaviour:
- Reset: all outputs 0; state IDLE; down-counter 0.
- States: IDLE, ARMED. All outputs are registered.

Priority per edge:
- rst beats everything else.
- clear governs flags, counters and double_evt.
- arm governs window control.
- Events resolve the window.

Flags and counters:
- Updated on every sampled event in any state.
- A pass_evt sets pass_called and increments pass_count; fail_evt does the same for fail_called/fail_count. Counters stick at 2^CNT_W-1.
- clear in the same cycle as an event: clear wins, so the flag/counter is 0 after the edge. Window resolution still uses the event.

IDLE:
- arm → ARMED. Latch timeout_cycles into the down-counter; status←00; busy←1.
- Events in IDLE update flags/counters only. status and done are unchanged.

ARMED:
- An event sampled in the arm cycle itself belongs to no window; it updates only flags/counters.
- pass_evt only → IDLE, done←1, status←01.
- fail_evt only → IDLE, done←1, status←10.
- Both in the same cycle → IDLE, status←10 (fail wins), double_evt←1.
- No event and down-counter≠0 → decrement. When it would reach 0 → IDLE, done←1, status←11.
- Resulting timing: arm sampled at edge E0 and timeout N → events are accepted at edges E1..EN and timeout resolves at EN. An event at EN beats the timeout.
- timeout_cycles=0: the counter is inactive and the window waits indefinitely.
- arm while ARMED: restart the window (reload counter, status←00), no done pulse. An event in that same cycle is not attributed to either window.
- Event in the cycle right after done (now IDLE): sets double_evt only if it arrives within one cycle of resolution.

Timing and holding:
- done is high exactly one cycle.
- status holds until the next arm or rst.
- Latency from event to done/status is 1 cycle.

Optional Feature:
- Macro: VGM_SVA_EXPECT_TRACKER_HIST_EN.
- With the macro: adds output `status_hist` [7:0]. On each done pulse it shifts left by 2 and inserts the new status in [1:0]. Reset and clear set it to 0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pass: rst 2 cycles, arm with timeout_cycles=5, pass_evt 3 cycles later → next cycle done=1 for 1 cycle, status=01, pass_called=1, pass_count=1, busy=0.
- Timeout: arm with timeout_cycles=4, no events → done at edge E4, status=11, both flags 0, counts 0. Repeat with pass_evt at E4 → status=01.
- Simultaneous: arm, then pass_evt and fail_evt in the same cycle → status=10, double_evt=1, pass_count=1, fail_count=1.
- Saturation and clear: CNT_W=2, 5 pass pulses in IDLE → pass_count=3, status unchanged 00, no done. Then clear asserted with a pass_evt → pass_count=0, pass_called=0.
- Re-arm and reset: arm (timeout 10), re-arm at cycle 3 with timeout 2 → timeout done 2 edges later, single done pulse. Separately, rst mid-window → busy=0, status=00, no done.
- History (macro on): windows resolve pass, fail, timeout → status_hist=8'b00_01_10_11.

Source files
------------

// File: rtl/vgm_sva_expect_tracker.sv
// vgm_sva_expect_tracker: registers expect pass/fail pulses into sticky flags, saturating counts and window results.
// Optional status_hist output via `define VGM_SVA_EXPECT_TRACKER_HIST_EN.
module vgm_sva_expect_tracker #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 pass_evt,
    input  logic                 fail_evt,
    input  logic                 clear,
    output logic                 pass_called,
    output logic                 fail_called,
    output logic                 double_evt,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_W-1:0]     pass_count,
`ifdef VGM_SVA_EXPECT_TRACKER_HIST_EN
    output logic [CNT_W-1:0]     fail_count,
    output logic [7:0]           status_hist
`else
    output logic [CNT_W-1:0]     fail_count
`endif
);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t               state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [CNT_W-1:0]     pass_cnt_q, fail_cnt_q, pass_cnt_d, fail_cnt_d;
    logic                 pass_called_q, fail_called_q, double_q, double_d, done_q;
    logic [1:0]           status_q, res_status;
    logic                 any_evt, win_evt, tmo, resolve;
    // Events in an arm cycle belong to no window; only an unarmed ARMED cycle can resolve.
    always_comb begin
        any_evt    = pass_evt | fail_evt;
        win_evt    = state_q == ARMED && !arm && any_evt;
        tmo        = state_q == ARMED && !arm && !any_evt && cnt_q == TIMEOUT_W'(1);
        resolve    = win_evt | tmo;
        res_status = fail_evt ? 2'b10 : pass_evt ? 2'b01 : 2'b11;
        pass_cnt_d = clear ? '0 : (pass_evt && !(&pass_cnt_q)) ? pass_cnt_q + 1'b1 : pass_cnt_q;
        fail_cnt_d = clear ? '0 : (fail_evt && !(&fail_cnt_q)) ? fail_cnt_q + 1'b1 : fail_cnt_q;
        double_d   = !clear && (double_q || (pass_evt && fail_evt) || (done_q && any_evt));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            pass_called_q <= 1'b0;
            fail_called_q <= 1'b0;
            double_q      <= 1'b0;
            done_q        <= 1'b0;
            status_q      <= 2'b00;
        end else begin
            pass_cnt_q    <= pass_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            pass_called_q <= !clear && (pass_called_q || pass_evt);
            fail_called_q <= !clear && (fail_called_q || fail_evt);
            double_q      <= double_d;
            done_q        <= resolve;
            if (arm) begin
                state_q  <= ARMED;
                cnt_q    <= timeout_cycles;
                status_q <= 2'b00;
            end else if (resolve) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                status_q <= res_status;
            end else if (state_q == ARMED && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
`ifdef VGM_SVA_EXPECT_TRACKER_HIST_EN
    logic [7:0] hist_q;
    always_ff @(posedge clk) begin
        if (rst || clear) hist_q <= '0;
        else if (resolve) hist_q <= {hist_q[5:0], res_status};
    end
    assign status_hist = hist_q;
`endif
    assign pass_called = pass_called_q;
    assign fail_called = fail_called_q;
    assign double_evt  = double_q;
    assign busy        = state_q == ARMED;
    assign done        = done_q;
    assign status      = status_q;
    assign pass_count  = pass_cnt_q;
    assign fail_count  = fail_cnt_q;
endmodule

// File: tb/tb_vgm_sva_expect_tracker.sv
// tb_vgm_sva_expect_tracker: directed checks of the expect tracker with CNT_W=2 to reach saturation.
module tb_vgm_sva_expect_tracker;
    logic        clk = 0, rst = 1, arm = 0, pass_evt = 0, fail_evt = 0, clear = 0;
    logic [15:0] timeout_cycles = 0;
    logic        pass_called, fail_called, double_evt, busy, done;
    logic [1:0]  status, pass_count, fail_count;
    int          errors = 0, checks = 0;
`ifdef VGM_SVA_EXPECT_TRACKER_HIST_EN
    logic [7:0]  status_hist;
`endif
    vgm_sva_expect_tracker #(.CNT_W(2), .TIMEOUT_W(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .timeout_cycles(timeout_cycles),
        .pass_evt(pass_evt), .fail_evt(fail_evt), .clear(clear),
        .pass_called(pass_called), .fail_called(fail_called), .double_evt(double_evt),
        .busy(busy), .done(done), .status(status),
        .pass_count(pass_count),
`ifdef VGM_SVA_EXPECT_TRACKER_HIST_EN
        .fail_count(fail_count), .status_hist(status_hist)
`else
        .fail_count(fail_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        tick(); tick();
        rst = 0;
        chk("rst_busy", 16'(busy), 0); chk("rst_done", 16'(done), 0);
        chk("rst_status", 16'(status), 0); chk("rst_pcnt", 16'(pass_count), 0);
        chk("rst_fcnt", 16'(fail_count), 0); chk("rst_pflag", 16'(pass_called), 0);
        chk("rst_fflag", 16'(fail_called), 0); chk("rst_double", 16'(double_evt), 0);
        // pass window: arm at E0 with 5, pass at E3
        arm = 1; timeout_cycles = 5; tick(); arm = 0;
        chk("pass_busy", 16'(busy), 1);
        tick(); tick();
        pass_evt = 1; tick(); pass_evt = 0;
        chk("pass_done", 16'(done), 1); chk("pass_status", 16'(status), 1);
        chk("pass_flag", 16'(pass_called), 1); chk("pass_cnt", 16'(pass_count), 1);
        chk("pass_busy0", 16'(busy), 0);
        tick();
        chk("pass_done1cyc", 16'(done), 0); chk("pass_status_hold", 16'(status), 1);
        chk("pass_nodouble", 16'(double_evt), 0);
        clear = 1; tick(); clear = 0;
        chk("clear_pcnt", 16'(pass_count), 0); chk("clear_pflag", 16'(pass_called), 0);
        // timeout window of 4
        arm = 1; timeout_cycles = 4; tick(); arm = 0;
        tick(); tick(); tick();
        chk("tmo_e3_done", 16'(done), 0); chk("tmo_e3_busy", 16'(busy), 1);
        tick();
        chk("tmo_done", 16'(done), 1); chk("tmo_status", 16'(status), 3);
        chk("tmo_pflag", 16'(pass_called), 0); chk("tmo_fflag", 16'(fail_called), 0);
        chk("tmo_pcnt", 16'(pass_count), 0); chk("tmo_fcnt", 16'(fail_count), 0);
        tick();
        chk("tmo_done_low", 16'(done), 0);
        // event at E4 beats the timeout
        arm = 1; timeout_cycles = 4; tick(); arm = 0;
        chk("rearm_status_cleared", 16'(status), 0);
        tick(); tick(); tick();
        pass_evt = 1; tick(); pass_evt = 0;
        chk("edge_done", 16'(done), 1); chk("edge_status", 16'(status), 1);
        tick();
        // simultaneous pass+fail, infinite window
        clear = 1; tick(); clear = 0;
        arm = 1; timeout_cycles = 0; tick(); arm = 0;
        tick(); tick(); tick();
        chk("inf_busy", 16'(busy), 1); chk("inf_nodone", 16'(done), 0);
        pass_evt = 1; fail_evt = 1; tick(); pass_evt = 0; fail_evt = 0;
        chk("sim_done", 16'(done), 1); chk("sim_status", 16'(status), 2);
        chk("sim_double", 16'(double_evt), 1);
        chk("sim_pcnt", 16'(pass_count), 1); chk("sim_fcnt", 16'(fail_count), 1);
        tick();
        // event right after resolution flags double
        clear = 1; tick(); clear = 0;
        chk("clr_double", 16'(double_evt), 0);
        arm = 1; tick(); arm = 0;
        fail_evt = 1; tick(); fail_evt = 0;
        chk("fail_status", 16'(status), 2); chk("fail_nodouble", 16'(double_evt), 0);
        pass_evt = 1; tick(); pass_evt = 0;
        chk("late_double", 16'(double_evt), 1); chk("late_nodone", 16'(done), 0);
        chk("late_status", 16'(status), 2);
        tick();
        // saturation in IDLE
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            pass_evt = 1; tick(); pass_evt = 0;
            chk("sat_nodone", 16'(done), 0);
            tick();
        end
        chk("sat_pcnt", 16'(pass_count), 3); chk("sat_status", 16'(status), 0);
        chk("sat_nodouble", 16'(double_evt), 0);
        clear = 1; pass_evt = 1; tick(); clear = 0; pass_evt = 0;
        chk("clrwin_pcnt", 16'(pass_count), 0); chk("clrwin_pflag", 16'(pass_called), 0);
        // re-arm mid-window
        arm = 1; timeout_cycles = 10; tick(); arm = 0;
        tick(); tick();
        arm = 1; timeout_cycles = 2; tick(); arm = 0;
        chk("rearm_busy", 16'(busy), 1); chk("rearm_nodone", 16'(done), 0);
        tick();
        chk("rearm_e1_done", 16'(done), 0);
        tick();
        chk("rearm_tmo_done", 16'(done), 1); chk("rearm_tmo_status", 16'(status), 3);
        tick();
        chk("rearm_single", 16'(done), 0);
        // reset mid-window
        arm = 1; timeout_cycles = 10; tick(); arm = 0;
        tick();
        rst = 1; tick(); rst = 0;
        chk("rstmid_busy", 16'(busy), 0); chk("rstmid_status", 16'(status), 0);
        chk("rstmid_done", 16'(done), 0);
        tick();
        chk("rstmid_done2", 16'(done), 0);
        // event in the arm cycle belongs to no window
        arm = 1; timeout_cycles = 3; pass_evt = 1; tick(); arm = 0; pass_evt = 0;
        chk("armevt_busy", 16'(busy), 1); chk("armevt_done", 16'(done), 0);
        chk("armevt_pcnt", 16'(pass_count), 1);
        tick(); tick(); tick();
        chk("armevt_tmo", 16'(status), 3);
        tick();
`ifdef VGM_SVA_EXPECT_TRACKER_HIST_EN
        clear = 1; tick(); clear = 0;
        chk("hist_clr", 16'(status_hist), 0);
        arm = 1; timeout_cycles = 0; tick(); arm = 0;
        pass_evt = 1; tick(); pass_evt = 0; tick();
        arm = 1; tick(); arm = 0;
        fail_evt = 1; tick(); fail_evt = 0; tick();
        arm = 1; timeout_cycles = 1; tick(); arm = 0;
        tick(); tick();
        chk("hist_seq", 16'(status_hist), 16'h001b);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
